// File: rtl/first_system_sequencer.sv
// first_system_sequencer
// Round-robin sharing of one external two-input gate datapath between two
// requesters. The winner's operands are latched, held on the datapath for
// EXEC_CYCLES cycles, and the datapath results are returned tagged with the
// requester ID.
// Optional macro FS_CHECK_EN: adds a sticky dp_err flag that checks the
// captured datapath results against the expected gate function.
module first_system_sequencer #(
   parameter int EXEC_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic a0,
   input  logic b0,
   input  logic req1,
   input  logic a1,
   input  logic b1,
   output logic gnt0,
   output logic gnt1,
   output logic busy,
   output logic dp_in1,
   output logic dp_in2,
   input  logic dp_out1,
   input  logic dp_out2,
   output logic rsp_valid,
   output logic rsp_id,
   output logic rsp_out1,
   output logic rsp_out2,
   output logic dp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

   state_t           state_q, state_d;
   logic             last_gnt_q, last_gnt_d;
   logic             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op1_q, op1_d;
   logic             op2_q, op2_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_out1_q, rsp_out1_d;
   logic             rsp_out2_q, rsp_out2_d;
   logic             win_s;
   logic             capture_s;
   logic             dp_in1_s, dp_in2_s;

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= 1'b1;
         sel_q       <= 1'b0;
         cnt_q       <= '0;
         op1_q       <= 1'b0;
         op2_q       <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_out1_q  <= 1'b0;
         rsp_out2_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_out1_q  <= rsp_out1_d;
         rsp_out2_q  <= rsp_out2_d;
      end
   end

   // Next-state logic: arbitration, operand latch, settle count and capture
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_out1_d  = rsp_out1_q;
      rsp_out2_d  = rsp_out2_q;
      capture_s   = 1'b0;
      // With both requesting, the one not granted last time wins
      win_s       = (req0 && req1) ? ~last_gnt_q : req1;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               op1_d      = win_s ? a1 : a0;
               op2_d      = win_s ? b1 : b0;
               sel_d      = win_s;
               last_gnt_d = win_s;
               cnt_d      = '0;
               gnt0_d     = ~win_s;
               gnt1_d     = win_s;
               state_d    = ST_EXEC;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               capture_s   = 1'b1;
               rsp_out1_d  = dp_out1;
               rsp_out2_d  = dp_out2;
               rsp_id_d    = sel_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               state_d     = ST_EXEC;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Datapath drive: operands only while executing, otherwise quiet
   always_comb begin
      dp_in1_s = 1'b0;
      dp_in2_s = 1'b0;
      if (state_q == ST_EXEC) begin
         dp_in1_s = op1_q;
         dp_in2_s = op2_q;
      end else begin
         dp_in1_s = 1'b0;
         dp_in2_s = 1'b0;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_out1  = rsp_out1_q;
   assign rsp_out2  = rsp_out2_q;
   assign dp_in1    = dp_in1_s;
   assign dp_in2    = dp_in2_s;

`ifdef FS_CHECK_EN
   logic dp_err_q, dp_err_d;

   // Sticky error: datapath out1 must be op1^op2 and out2 must be ~op2
   always_comb begin
      dp_err_d = dp_err_q;
      if (capture_s && ((dp_out1 != (op1_q ^ op2_q)) || (dp_out2 != ~op2_q))) begin
         dp_err_d = 1'b1;
      end else begin
         dp_err_d = dp_err_q;
      end
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dp_err_q <= 1'b0;
      end else begin
         dp_err_q <= dp_err_d;
      end
   end

   assign dp_err = dp_err_q;
`else
   assign dp_err = 1'b0;
`endif

endmodule

// File: tb/tb_first_system_sequencer.sv
// Testbench for first_system_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// cycle-schedule model (grant at start, response at start+EXEC).
module tb_first_system_sequencer;

   localparam int EXEC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0, a0 = 1'b0, b0 = 1'b0;
   logic req1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
   logic gnt0, gnt1, busy, dp_in1, dp_in2, dp_out1, dp_out2;
   logic rsp_valid, rsp_id, rsp_out1, rsp_out2, dp_err;
   logic fault = 1'b0;

   // second instance with a longer settle time
   logic q4 = 1'b0, a4 = 1'b0, b4 = 1'b0;
   logic g40, g41, busy4, d41, d42, o41, o42, rv4, rid4, ro41, ro42, err4;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   // external gate datapath models; fault forces out1 low
   assign dp_out1 = fault ? 1'b0 : ((dp_in1 & dp_in2) ^ (dp_in1 | dp_in2));
   assign dp_out2 = ~dp_in2;
   assign o41 = (d41 & d42) ^ (d41 | d42);
   assign o42 = ~d42;

   first_system_sequencer #(.EXEC_CYCLES(EXEC), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .dp_in1(dp_in1), .dp_in2(dp_in2),
      .dp_out1(dp_out1), .dp_out2(dp_out2), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .dp_err(dp_err));

   first_system_sequencer #(.EXEC_CYCLES(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0(1'b0), .a0(1'b0), .b0(1'b0), .req1(q4), .a1(a4), .b1(b4),
      .gnt0(g40), .gnt1(g41), .busy(busy4), .dp_in1(d41), .dp_in2(d42),
      .dp_out1(o41), .dp_out2(o42), .rsp_valid(rv4), .rsp_id(rid4),
      .rsp_out1(ro41), .rsp_out2(ro42), .dp_err(err4));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int cyc = 0;
   bit m_act = 1'b0;
   int m_start = 0;
   bit m_id = 1'b0, m_a = 1'b0, m_b = 1'b0, m_last = 1'b1;
   bit m_rid = 1'b0, m_r1 = 1'b0, m_r2 = 1'b0, m_err = 1'b0;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_act = 1'b0; m_last = 1'b1;
         m_rid = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0; m_err = 1'b0;
      end else begin
         if (m_act && cyc == m_start + EXEC - 1) begin
            bit o1, o2;
            o1 = fault ? 1'b0 : (m_a ^ m_b);
            o2 = ~m_b;
            m_rid = m_id; m_r1 = o1; m_r2 = o2;
`ifdef FS_CHECK_EN
            if (o1 != (m_a ^ m_b)) m_err = 1'b1;
`endif
         end
         if ((!m_act || cyc >= m_start + EXEC + 1) && (req0 || req1)) begin
            m_id = (req0 && req1) ? !m_last : req1;
            m_a = m_id ? a1 : a0;
            m_b = m_id ? b1 : b0;
            m_last = m_id;
            m_start = cyc + 1;
            m_act = 1'b1;
         end
      end
      cyc++;
   end

   // per-cycle compare of every output against the model
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         int d;
         bit run, drv;
         d = cyc - m_start;
         run = m_act && d >= 0 && d <= EXEC;
         drv = m_act && d >= 0 && d < EXEC;
         chk("m_gnt0", gnt0, m_act && d == 0 && !m_id);
         chk("m_gnt1", gnt1, m_act && d == 0 && m_id);
         chk("m_busy", busy, run);
         chk("m_dp_in1", dp_in1, drv && m_a);
         chk("m_dp_in2", dp_in2, drv && m_b);
         chk("m_rsp_valid", rsp_valid, m_act && d == EXEC);
         chk("m_rsp_id", rsp_id, m_rid);
         chk("m_rsp_out1", rsp_out1, m_r1);
         chk("m_rsp_out2", rsp_out2, m_r2);
         chk("m_dp_err", dp_err, m_err);
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int gc [8];
      int gi [8];
      int ng;

      // ---- reset state ----
      tick(3);
      chk_on = 1'b1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_gnt", {gnt0, gnt1}, 2'b00);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_out1, rsp_out2, dp_err}, 5'b0);
      chk("rst_dp", {dp_in1, dp_in2}, 2'b00);
      rst_n = 1'b1;

      // ---- reset mid-operation drops the operation ----
      req0 = 1'b1; a0 = 1'b1; b0 = 1'b0;   // sampled at edge 0
      tick(1);                              // cycle 1
      chk("mid_gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      tick(1);                              // cycle 2
      rst_n = 1'b0;
      for (int c = 3; c <= 8; c++) begin
         tick(1);
         if (c == 5) rst_n = 1'b1;
         chk("mid_busy", busy, 1'b0);
         chk("mid_rsp_valid", rsp_valid, 1'b0);
      end

      // ---- single request ----
      req0 = 1'b1; a0 = 1'b1; b0 = 1'b0;
      tick(1);                              // cycle 1
      chk("single_gnt0", gnt0, 1'b1);
      chk("single_dp_c1", {dp_in1, dp_in2}, 2'b10);
      req0 = 1'b0; a0 = 1'b0; b0 = 1'b1;   // late operand change ignored
      tick(1);
      chk("single_dp_c2", {dp_in1, dp_in2}, 2'b10);
      tick(1);
      chk("single_rsp", {rsp_valid, rsp_id, rsp_out1, rsp_out2}, 4'b1011);
      tick(1);
      chk("single_busy_c4", busy, 1'b0);
      chk("single_hold", {rsp_valid, rsp_out1, rsp_out2}, 3'b011);

      // ---- simultaneous requests after reset ----
      do_reset();
      req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
      req1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick(1);
         if (c == 1) begin chk("sim_gnt0", {gnt0, gnt1}, 2'b10); req0 = 1'b0; end
         if (c == 3) chk("sim_rsp0", {rsp_valid, rsp_id, rsp_out1, rsp_out2}, 4'b1000);
         if (c == 5) begin chk("sim_gnt1", {gnt0, gnt1}, 2'b01); req1 = 1'b0; end
         if (c == 7) chk("sim_rsp1", {rsp_valid, rsp_id, rsp_out1, rsp_out2}, 4'b1110);
      end

      // ---- fairness with both held high ----
      do_reset();
      req0 = 1'b1; req1 = 1'b1; a0 = 1'b1; b0 = 1'b0; a1 = 1'b1; b1 = 1'b1;
      ng = 0;
      for (int c = 1; c <= 30; c++) begin
         tick(1);
         if ((gnt0 || gnt1) && ng < 8) begin
            gc[ng] = c; gi[ng] = gnt1; ng++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("fair_count", ng, 8);
      for (int k = 0; k < ng; k++) begin
         chk("fair_cycle", gc[k], 1 + 4 * k);
         chk("fair_id", gi[k], k % 2);
      end
      tick(4);

      // ---- EXEC_CYCLES=4 instance ----
      do_reset();
      for (int op = 0; op < 2; op++) begin
         q4 = 1'b1; a4 = (op == 1); b4 = (op == 1);
         for (int c = 1; c <= 7; c++) begin
            tick(1);
            if (c == 1) q4 = 1'b0;
            chk("p4_gnt1", g41, c == 1);
            chk("p4_busy", busy4, c >= 1 && c <= 5);
            chk("p4_dp_in1", d41, (op == 1) && c >= 1 && c <= 4);
            chk("p4_dp_in2", d42, (op == 1) && c >= 1 && c <= 4);
            chk("p4_rsp_valid", rv4, c == 5);
            if (c == 5) chk("p4_rsp", {rid4, ro41, ro42}, (op == 1) ? 3'b100 : 3'b101);
         end
      end

`ifdef FS_CHECK_EN
      // ---- sticky datapath error ----
      do_reset();
      fault = 1'b1;
      req0 = 1'b1; a0 = 1'b1; b0 = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick(1);
         if (c == 1) req0 = 1'b0;
         if (c == 2) chk("err_before", dp_err, 1'b0);
         if (c == 3) chk("err_rise", {rsp_valid, dp_err}, 2'b11);
      end
      fault = 1'b0;
      req1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick(1);
         if (c == 1) req1 = 1'b0;
      end
      chk("err_sticky", dp_err, 1'b1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("err_clear", dp_err, 1'b0);
      tick(2);
`endif

      // ---- randomized traffic against the model ----
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         rst_n = ($urandom_range(0, 149) != 0);
         if (gnt0) begin
            req0 = ($urandom_range(0, 3) == 0);
            a0 = $urandom_range(0, 1); b0 = $urandom_range(0, 1);
         end else if (!req0) begin
            req0 = ($urandom_range(0, 2) == 0);
            a0 = $urandom_range(0, 1); b0 = $urandom_range(0, 1);
         end
         if (gnt1) begin
            req1 = ($urandom_range(0, 3) == 0);
            a1 = $urandom_range(0, 1); b1 = $urandom_range(0, 1);
         end else if (!req1) begin
            req1 = ($urandom_range(0, 2) == 0);
            a1 = $urandom_range(0, 1); b1 = $urandom_range(0, 1);
         end
      end
      req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
      tick(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/first_system_sequencer.md
Name: first_system_sequencer

Overview:
- Time-shares one two-input gate datapath between two requesters.
- The datapath computes out1 = (in1 AND in2) XOR (in1 OR in2) and out2 = NOT in2.
- The block arbitrates round-robin, latches the winner's operands, drives the datapath for a programmable settle time, captures the results and returns them tagged with the requester ID.
- It sits between requester logic and the external gate datapath instance.

Parameters:
- EXEC_CYCLES, default 2: cycles operands are held on the datapath before capture. Legal range 1..15.
- CNT_W, default 4: width of the internal settle counter. Must satisfy 2^CNT_W > EXEC_CYCLES.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  requester 0 request.
- a0  in  1  requester 0 operand in1.
- b0  in  1  requester 0 operand in2.
- req1  in  1  requester 1 request.
- a1  in  1  requester 1 operand in1.
- b1  in  1  requester 1 operand in2.
- gnt0  out  1  one-cycle grant pulse to requester 0.
- gnt1  out  1  one-cycle grant pulse to requester 1.
- busy  out  1  high while state is not IDLE.
- dp_in1  out  1  drive to datapath in1.
- dp_in2  out  1  drive to datapath in2.
- dp_out1  in  1  datapath out1.
- dp_out2  in  1  datapath out2.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  1  requester ID of the result.
- rsp_out1  out  1  captured out1.
- rsp_out2  out  1  captured out2.
- dp_err  out  1  sticky mismatch flag. Tied 0 unless FS_CHECK_EN is defined.

Behaviour:
- One clock domain: clk. Reset rst_n is synchronous and active-low. All outputs are registered except dp_in1/dp_in2, which decode from registered state and operands.
- Reset values: state=IDLE, last_gnt=1 (requester 0 wins first), counter=0, operand regs=0. Outputs gnt0=gnt1=busy=rsp_valid=rsp_id=rsp_out1=rsp_out2=dp_err=0 and dp_in1=dp_in2=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Samples req0/req1 each edge.
  - If only one is high, that requester wins.
  - If both are high, the requester other than last_gnt wins.
  - On a win: latch the winner's a/b into the operand regs, set sel=winner and last_gnt=winner, counter=0, pulse gnt<sel> for the next cycle, go to EXEC.
  - With no request, stay in IDLE.
- EXEC:
  - dp_in1/dp_in2 = operand regs.
  - Counter increments each cycle.
  - When counter == EXEC_CYCLES-1: capture dp_out1/dp_out2 into rsp_out1/rsp_out2, rsp_id=sel, go to RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle; dp_in* = 0.
  - Next state is always IDLE. No request is sampled in RESP.
- Outside EXEC, dp_in1=dp_in2=0.
- Latency:
  - Request sampled at edge T, so gnt is high in cycle T+1.
  - dp_in* is driven in cycles T+1..T+EXEC_CYCLES.
  - rsp_valid is high in cycle T+EXEC_CYCLES+1.
  - Minimum spacing between grants is EXEC_CYCLES+2 cycles.
- Handshake:
  - Requester holds req and its operands stable until it sees gnt.
  - Requester deasserts req in the cycle after gnt. A req still high when the FSM returns to IDLE is a new request.
  - Operand changes after the latch edge have no effect.
- rsp_out1, rsp_out2 and rsp_id hold their values until the next capture; only rsp_valid pulses.
- Reset mid-operation: at the next edge with rst_n=0, all state returns to reset values and the in-flight operation is dropped. No rsp_valid is issued for it and no grant is reissued.
- No state uses an illegal encoding. Unreachable encodings go to IDLE.

Optional Feature:
- Macro: FS_CHECK_EN.
- Defined:
  - At the capture edge, compare dp_out1 against (op1 XOR op2), which equals the AND/OR/XOR composition, and dp_out2 against NOT op2.
  - On any mismatch, set dp_err at that edge.
  - dp_err is sticky and clears only on reset.
- Not defined: dp_err is constant 0 and no compare logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset: reset sequence below, with EXEC_CYCLES=2 -> all outputs 0 throughout.
  - Pulse req0 at cycle 0 with a0=1, b0=0.
  - Assert rst_n=0 at cycle 2 for 3 cycles.
  - Release with no requests.
  - Expect no rsp_valid, and busy=0 from the first reset edge onward.
- Single request: req0=1, a0=1, b0=0 sampled at edge 0, dropped after gnt -> required response below.
  - gnt0=1 in cycle 1.
  - dp_in1=1, dp_in2=0 in cycles 1-2.
  - rsp_valid=1 in cycle 3 with rsp_id=0, rsp_out1=1, rsp_out2=1.
  - busy=0 in cycle 4.
- Simultaneous requests after reset: req0 (a=1,b=1) and req1 (a=0,b=1) both at edge 0 -> grants below.
  - gnt0 in cycle 1; rsp in cycle 3 with id=0, out1=0, out2=0.
  - gnt1 in cycle 5; rsp in cycle 7 with id=1, out1=1, out2=0.
- Fairness: req0 and req1 held high continuously and re-raised after each grant for 8 grants -> grant order 0,1,0,1,0,1,0,1, one grant every 4 cycles.
- Parameter: EXEC_CYCLES=4, req1 with a1=0, b1=0 -> gnt1 in cycle 1, dp_in* driven in cycles 1-4, rsp_valid in cycle 5 with out1=0, out2=1.
- FS_CHECK_EN defined, datapath model forces dp_out1=0 -> dp_err stays 1 until rst_n=0.
  - Request a=1, b=0.
  - dp_err rises in the rsp_valid cycle.
  - A later correct operation leaves dp_err=1.
  - dp_err clears only on rst_n=0.
